uart_rx_cmd: RTL

- Serial front end of the command path: 8N1 UART receiver that deframes bytes from the host line into a 4-bit command code and a 4-bit data nibble.
- Each received byte splits as low nibble = instrucao, high nibble = dado, matching the {dado, instrucao} layout the command handler displays on its LEDs.
- Output feeds the command handler directly. instrucao is a one-cycle strobe and otherwise reads 0, so the handler's idle state sees "no command" between frames.

---
 rtl/uart_rx_cmd.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver delivering {dado, instrucao} per byte; define UART_RX_PARITY_EN for 8E1
module uart_rx_cmd #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] instrucao,
  output logic [3:0] dado,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HLAST = W'(HALF_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic good, bad, ok;
`ifdef UART_RX_PARITY_EN
  logic par_err, par_err_n;
  assign ok = rx_s & ~par_err;
`else
  assign ok = rx_s;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    good = 1'b0;
    bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n = par_err;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == HLAST) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_n = idx == 3'd7 ? PARITY : DATA;
`else
        state_n = idx == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == LAST) begin
        cnt_n = '0;
        par_err_n = ^{rx_s, sh};
        state_n = STOP;
      end
`endif
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        good = ok;
        bad = ~ok;
        state_n = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : WAIT_HIGH;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      instrucao <= 4'h0;
      dado <= 4'h0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      instrucao <= good ? sh[3:0] : 4'h0;
      dado <= good ? sh[7:4] : dado;
      cmd_valid <= good;
      frame_err <= bad;
`ifdef UART_RX_PARITY_EN
      par_err <= par_err_n;
`endif
    end
  end
endmodule
